// File: rtl/disp_pkg.sv
// Shared types and width helpers for the row-disparity engine and its SAD lanes.
// The *_BITS constants are the default-configuration widths; modules derive their own from parameters.
package disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_REDUCE,
      ST_EMIT
   } state_e;

   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int sad_bits_for(input int win, input int data_size);
      return $clog2(win * win * ((1 << data_size) - 1) + 1);
   endfunction

   localparam int SAD_BITS  = sad_bits_for(15, 8);
   localparam int DISP_BITS = bits_for(64);
   localparam int COL_BITS  = bits_for(64);

   function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/sad_lane.sv
// One disparity candidate: sums |L-R| over a WIN-pixel column each enabled cycle.
// An illegal candidate reports all-ones so it can never beat a legal one.
module sad_lane
   import disp_pkg::*;
#(
   parameter int WIN       = 15,
   parameter int DATA_SIZE = 8,
   parameter int SAD_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en_i,
   input  logic                     clr_i,
   input  logic                     illegal_i,
   input  logic [WIN*DATA_SIZE-1:0] pix_l_i,
   input  logic [WIN*DATA_SIZE-1:0] pix_r_i,
   output logic [SAD_W-1:0]         sad_o
);

   logic [SAD_W-1:0] acc_q;
   logic [SAD_W-1:0] col_sum_d;

   always_comb begin
      col_sum_d = '0;
      for (int r = 0; r < WIN; r++) begin
         col_sum_d = col_sum_d + SAD_W'(absdiff(32'(pix_l_i[r*DATA_SIZE +: DATA_SIZE]),
                                                32'(pix_r_i[r*DATA_SIZE +: DATA_SIZE])));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (clr_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_q + col_sum_d;
      end
   end

   assign sad_o = illegal_i ? '1 : acc_q;

endmodule

// File: rtl/disp_row_engine.sv
// Streaming winner-take-all SAD disparity over a column range of one WIN-row band pair.
//   state     | meaning
//   ST_IDLE   | band_ready high, waiting for a band
//   ST_ACCUM  | lanes accumulate one window column per cycle (k counts down)
//   ST_REDUCE | compare tree over lanes and running best; lanes clear
//   ST_EMIT   | out_valid high, held until out_ready
module disp_row_engine
   import disp_pkg::*;
#(
   parameter int WIN          = 15,
   parameter int DATA_SIZE    = 8,
   parameter int IMG_W        = 64,
   parameter int MAX_DISP     = 64,
   parameter int DISP_THREADS = 16,
   parameter int MAX_SAD      = (1 << sad_bits_for(WIN, DATA_SIZE)) - 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_SIZE*IMG_W*WIN-1:0]    band_L,
   input  logic [DATA_SIZE*IMG_W*WIN-1:0]    band_R,
   input  logic [bits_for(IMG_W)-1:0]        col_start,
   input  logic [bits_for(IMG_W)-1:0]        col_end,
   input  logic                              band_valid,
   output logic                              band_ready,
   output logic [bits_for(MAX_DISP)-1:0]     out_disp,
   output logic [bits_for(IMG_W)-1:0]        out_col,
   output logic                              out_invalid,
   output logic                              out_last,
   output logic                              out_valid,
   input  logic                              out_ready
);

   localparam int HALF     = (WIN - 1) / 2;
   localparam int G        = MAX_DISP / DISP_THREADS;
   localparam int SAD_W    = sad_bits_for(WIN, DATA_SIZE);
   localparam int DISP_W   = bits_for(MAX_DISP);
   localparam int COL_W    = bits_for(IMG_W);
   localparam int K_W      = bits_for(WIN);
   localparam int G_W      = bits_for(G);
   localparam int LANE_W   = bits_for(DISP_THREADS);
   localparam int NPAD     = 1 << $clog2(DISP_THREADS);
   localparam int BAND_W   = DATA_SIZE * IMG_W * WIN;
   localparam int COLPIX_W = DATA_SIZE * WIN;

   state_e              state_q;
   logic [BAND_W-1:0]   band_l_q, band_r_q;
   logic [COL_W-1:0]    col_q, end_q;
   logic [G_W-1:0]      grp_q;
   logic [K_W-1:0]      k_q;
   logic [SAD_W-1:0]    best_sad_q, best_sad_d;
   logic [DISP_W-1:0]   best_disp_q, best_disp_d;
   logic                band_ready_q, out_valid_q, out_invalid_q, out_last_q;
   logic [DISP_W-1:0]   out_disp_q;
   logic [COL_W-1:0]    out_col_q;
   logic                accept;
   logic [COL_W-1:0]    col_next;
   logic                lane_en, lane_clr;
   int                  xl;
   logic [COLPIX_W-1:0] pix_l;
   logic [SAD_W-1:0]    lane_sad [DISP_THREADS];
   logic [SAD_W-1:0]    node_sad [2*NPAD-1];
   logic [LANE_W-1:0]   node_idx [2*NPAD-1];

   function automatic logic is_edge(input logic [COL_W-1:0] c);
      return (int'(c) < HALF) || (int'(c) > IMG_W - 1 - HALF);
   endfunction

   assign accept   = (state_q == ST_IDLE) && band_ready_q && band_valid;
   assign col_next = col_q + 1'b1;
   assign lane_en  = (state_q == ST_ACCUM);
   assign lane_clr = (state_q == ST_REDUCE);

   // Band storage is datapath only; a reset simply leaves stale pixels that are never used.
   always_ff @(posedge clk) begin
      if (accept) begin
         band_l_q <= band_L;
         band_r_q <= band_R;
      end
   end

   always_comb begin
      xl = int'(col_q) - HALF + int'(k_q);
      if (xl < 0 || xl >= IMG_W) xl = 0;
      pix_l = '0;
      for (int r = 0; r < WIN; r++) begin
         pix_l[r*DATA_SIZE +: DATA_SIZE] = band_l_q[(r*IMG_W + xl)*DATA_SIZE +: DATA_SIZE];
      end
   end

   for (genvar j = 0; j < DISP_THREADS; j++) begin : g_lane
      int                  d;
      int                  xr;
      logic                illegal;
      logic [COLPIX_W-1:0] pix_r;

      // Out-of-band right-image indices only occur for illegal candidates, whose sum is ignored.
      always_comb begin
         d       = int'(grp_q) * DISP_THREADS + j;
         illegal = (int'(col_q) - d) < HALF;
         xr      = xl - d;
         if (xr < 0 || xr >= IMG_W) xr = 0;
         pix_r = '0;
         for (int r = 0; r < WIN; r++) begin
            pix_r[r*DATA_SIZE +: DATA_SIZE] = band_r_q[(r*IMG_W + xr)*DATA_SIZE +: DATA_SIZE];
         end
      end

      sad_lane #(
         .WIN       (WIN),
         .DATA_SIZE (DATA_SIZE),
         .SAD_W     (SAD_W)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_i      (lane_en),
         .clr_i     (lane_clr),
         .illegal_i (illegal),
         .pix_l_i   (pix_l),
         .pix_r_i   (pix_r),
         .sad_o     (lane_sad[j])
      );
   end

   // Heap-ordered tree; the right child wins only when strictly smaller, so ties keep the lower d.
   always_comb begin
      for (int n = 0; n < 2*NPAD-1; n++) begin
         node_sad[n] = '1;
         node_idx[n] = '0;
      end
      for (int i = 0; i < DISP_THREADS; i++) begin
         node_sad[NPAD-1+i] = lane_sad[i];
         node_idx[NPAD-1+i] = LANE_W'(i);
      end
      for (int n = NPAD-2; n >= 0; n--) begin
         if (node_sad[2*n+2] < node_sad[2*n+1]) begin
            node_sad[n] = node_sad[2*n+2];
            node_idx[n] = node_idx[2*n+2];
         end else begin
            node_sad[n] = node_sad[2*n+1];
            node_idx[n] = node_idx[2*n+1];
         end
      end
   end

   // Earlier groups hold smaller d, so the running best only yields to a strictly smaller SAD.
   always_comb begin
      best_sad_d  = best_sad_q;
      best_disp_d = best_disp_q;
      if (node_sad[0] < best_sad_q) begin
         best_sad_d  = node_sad[0];
         best_disp_d = DISP_W'(int'(grp_q) * DISP_THREADS + int'(node_idx[0]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         band_ready_q  <= 1'b0;
         col_q         <= '0;
         end_q         <= '0;
         grp_q         <= '0;
         k_q           <= '0;
         best_sad_q    <= '1;
         best_disp_q   <= '0;
         out_valid_q   <= 1'b0;
         out_disp_q    <= '0;
         out_col_q     <= '0;
         out_invalid_q <= 1'b0;
         out_last_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  band_ready_q <= 1'b0;
                  col_q        <= col_start;
                  end_q        <= col_end;
                  grp_q        <= '0;
                  k_q          <= K_W'(WIN - 1);
                  best_sad_q   <= '1;
                  best_disp_q  <= '0;
                  if (col_start > col_end) begin
                     state_q <= ST_IDLE;
                  end else if (is_edge(col_start)) begin
                     state_q       <= ST_EMIT;
                     out_valid_q   <= 1'b1;
                     out_disp_q    <= '0;
                     out_col_q     <= col_start;
                     out_invalid_q <= 1'b1;
                     out_last_q    <= (col_start == col_end);
                  end else begin
                     state_q <= ST_ACCUM;
                  end
               end else begin
                  band_ready_q <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (k_q == '0) begin
                  state_q <= ST_REDUCE;
                  k_q     <= K_W'(WIN - 1);
               end else begin
                  k_q <= k_q - 1'b1;
               end
            end
            ST_REDUCE: begin
               best_sad_q  <= best_sad_d;
               best_disp_q <= best_disp_d;
               if (grp_q == G_W'(G - 1)) begin
                  state_q       <= ST_EMIT;
                  out_valid_q   <= 1'b1;
                  out_disp_q    <= best_disp_d;
                  out_col_q     <= col_q;
                  out_invalid_q <= (int'(best_sad_d) > MAX_SAD);
                  out_last_q    <= (col_q == end_q);
               end else begin
                  grp_q   <= grp_q + 1'b1;
                  state_q <= ST_ACCUM;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     state_q      <= ST_IDLE;
                     out_valid_q  <= 1'b0;
                     band_ready_q <= 1'b1;
                  end else begin
                     col_q       <= col_next;
                     grp_q       <= '0;
                     k_q         <= K_W'(WIN - 1);
                     best_sad_q  <= '1;
                     best_disp_q <= '0;
                     if (is_edge(col_next)) begin
                        out_valid_q   <= 1'b1;
                        out_disp_q    <= '0;
                        out_col_q     <= col_next;
                        out_invalid_q <= 1'b1;
                        out_last_q    <= (col_next == end_q);
                     end else begin
                        state_q     <= ST_ACCUM;
                        out_valid_q <= 1'b0;
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign band_ready  = band_ready_q;
   assign out_valid   = out_valid_q;
   assign out_disp    = out_disp_q;
   assign out_col     = out_col_q;
   assign out_invalid = out_invalid_q;
   assign out_last    = out_last_q;

endmodule

// File: tb/tb_disp_row_engine.sv
// Directed bench for disp_row_engine: vector table of single-column bands plus
// hand-written sequences for backpressure, legality at the left edge, empty range and reset.
module tb_disp_row_engine;
   import disp_pkg::*;

   localparam int WIN   = 15;
   localparam int DS    = 8;
   localparam int IMG_W = 64;
   localparam int MAXD  = 64;
   localparam int HALF  = 7;
   localparam int BW    = DS * IMG_W * WIN;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [BW-1:0]        band_l, band_r;
   logic [COL_BITS-1:0]  col_start, col_end;
   logic                 band_valid, out_ready;
   logic                 band_ready, out_valid, out_invalid, out_last;
   logic [DISP_BITS-1:0] out_disp;
   logic [COL_BITS-1:0]  out_col;
   logic                 band_ready2, out_valid2, out_invalid2, out_last2;
   logic [DISP_BITS-1:0] out_disp2;
   logic [COL_BITS-1:0]  out_col2;

   always #5 clk = ~clk;

   disp_row_engine u_dut (
      .clk(clk), .rst_n(rst_n), .band_L(band_l), .band_R(band_r),
      .col_start(col_start), .col_end(col_end), .band_valid(band_valid),
      .band_ready(band_ready), .out_disp(out_disp), .out_col(out_col),
      .out_invalid(out_invalid), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   disp_row_engine #(.MAX_SAD(0)) u_dut_strict (
      .clk(clk), .rst_n(rst_n), .band_L(band_l), .band_R(band_r),
      .col_start(col_start), .col_end(col_end), .band_valid(band_valid),
      .band_ready(band_ready2), .out_disp(out_disp2), .out_col(out_col2),
      .out_invalid(out_invalid2), .out_last(out_last2), .out_valid(out_valid2),
      .out_ready(out_ready)
   );

   logic [7:0] base [WIN][IMG_W];
   logic [7:0] rnd2 [WIN][IMG_W];
   logic [7:0] img_l [WIN][IMG_W];
   logic [7:0] img_r [WIN][IMG_W];

   int n_chk  = 0;
   int n_pass = 0;

   // shift >= 0: R(x) = L(x+shift); -1: both bands 0x80; -2: unrelated R. disp -1: take the model's answer.
   typedef struct {
      int shift;
      int cs;
      int ce;
      int disp;
      int inv;
      int inv2;
      int lat;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic make_tex(input int s);
      for (int r = 0; r < WIN; r++) begin
         for (int x = 0; x < IMG_W; x++) begin
            if (s == -1) begin
               img_l[r][x] = 8'h80;
               img_r[r][x] = 8'h80;
            end else begin
               img_l[r][x] = base[r][x];
               if (s == -2 || x + s >= IMG_W) img_r[r][x] = rnd2[r][x];
               else img_r[r][x] = base[r][x+s];
            end
            band_l[(r*IMG_W + x)*DS +: DS] = img_l[r][x];
            band_r[(r*IMG_W + x)*DS +: DS] = img_r[r][x];
         end
      end
   endtask

   task automatic ref_wta(input int c, output int bd, output int bs);
      int s;
      bd = 0;
      bs = 32'h7fff_ffff;
      for (int d = 0; d < MAXD; d++) begin
         if (c - d >= HALF) begin
            s = 0;
            for (int r = 0; r < WIN; r++) begin
               for (int k = 0; k < WIN; k++) begin
                  int a, b;
                  a = int'(img_l[r][c-HALF+k]);
                  b = int'(img_r[r][c-HALF+k-d]);
                  s += (a > b) ? a - b : b - a;
               end
            end
            if (s < bs) begin
               bs = s;
               bd = d;
            end
         end
      end
   endtask

   task automatic wait_ready();
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (band_ready) break;
      end
      chk("ready_wait", band_ready, 1);
   endtask

   // Hands one band over; afterwards the inputs are scrambled so only registered copies can be used.
   task automatic launch(input int cs, input int ce);
      wait_ready();
      col_start  = COL_BITS'(cs);
      col_end    = COL_BITS'(ce);
      band_valid = 1'b1;
      @(posedge clk);
      #1;
      band_valid = 1'b0;
      band_l     = ~band_l;
      band_r     = ~band_r;
      col_start  = '0;
      col_end    = '0;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) chk("valid_wait", out_valid, 1);
   endtask

   initial begin
      int lat, bd, bs, exp_d, d0, c0, l0, i0, stable, seen;

      for (int r = 0; r < WIN; r++) begin
         for (int x = 0; x < IMG_W; x++) begin
            base[r][x] = 8'($urandom_range(0, 255));
            rnd2[r][x] = 8'($urandom_range(0, 255));
         end
      end

      vecs[0]  = '{5,  32, 32, 5,  0, 0, 65};
      vecs[1]  = '{5,   3,  3, 0,  1, 1, 1};
      vecs[2]  = '{-1, 20, 20, 0,  0, 0, 65};
      vecs[3]  = '{5,   7,  7, 0,  0, 1, 65};
      vecs[4]  = '{5,   6,  6, 0,  1, 1, 1};
      vecs[5]  = '{5,  56, 56, 5,  0, 0, 65};
      vecs[6]  = '{5,  57, 57, 0,  1, 1, 1};
      vecs[7]  = '{20, 40, 40, 20, 0, 0, 65};
      vecs[8]  = '{37, 50, 50, 37, 0, 0, 65};
      vecs[9]  = '{49, 56, 56, 49, 0, 0, 65};
      vecs[10] = '{-2, 32, 32, -1, 0, 1, 65};
      vecs[11] = '{0,  20, 20, 0,  0, 0, 65};
      vecs[12] = '{5,   0,  0, 0,  1, 1, 1};
      vecs[13] = '{5,  63, 63, 0,  1, 1, 1};

      rst_n      = 1'b0;
      band_valid = 1'b0;
      out_ready  = 1'b1;
      col_start  = '0;
      col_end    = '0;
      band_l     = '0;
      band_r     = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", band_ready, 0);
      chk("rst_outs", {out_valid, out_disp, out_col, out_invalid, out_last}, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         make_tex(vecs[i].shift);
         exp_d = vecs[i].disp;
         if (exp_d < 0) begin
            ref_wta(vecs[i].cs, bd, bs);
            exp_d = bd;
         end
         launch(vecs[i].cs, vecs[i].ce);
         wait_valid(lat);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_disp", i), out_disp, exp_d);
         chk($sformatf("v%0d_col", i), out_col, vecs[i].cs);
         chk($sformatf("v%0d_invalid", i), out_invalid, vecs[i].inv);
         chk($sformatf("v%0d_invalid_strict", i), out_invalid2, vecs[i].inv2);
         chk($sformatf("v%0d_last", i), out_last, 1);
         @(negedge clk);
         chk($sformatf("v%0d_ready_after", i), band_ready, 1);
         chk($sformatf("v%0d_valid_after", i), out_valid, 0);
      end

      // Four columns under backpressure: each beat must hold for 10 stalled cycles.
      make_tex(5);
      out_ready = 1'b0;
      launch(30, 33);
      for (int b = 0; b < 4; b++) begin
         wait_valid(lat);
         d0 = out_disp; c0 = out_col; l0 = out_last; i0 = out_invalid;
         stable = 1;
         repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_disp != d0 || out_col != c0 || out_last != l0 || out_invalid != i0)
               stable = 0;
         end
         chk($sformatf("stall%0d_stable", b), stable, 1);
         chk($sformatf("stall%0d_col", b), c0, 30 + b);
         chk($sformatf("stall%0d_disp", b), d0, 5);
         chk($sformatf("stall%0d_invalid", b), i0, 0);
         chk($sformatf("stall%0d_last", b), l0, (b == 3) ? 1 : 0);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         chk($sformatf("stall%0d_drop", b), out_valid, 0);
      end
      chk("stall_ready_after", band_ready, 1);
      out_ready = 1'b1;

      // Column 8: only d <= 1 is legal even though the true shift is 5.
      make_tex(5);
      ref_wta(8, bd, bs);
      launch(8, 8);
      wait_valid(lat);
      chk("c8_latency", lat, 65);
      chk("c8_model", out_disp, bd);
      chk("c8_legal", (out_disp <= 1) ? 1 : 0, 1);

      // Empty range: accepted, nothing emitted.
      launch(10, 5);
      seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      chk("empty_novalid", seen, 0);
      chk("empty_ready", band_ready, 1);

      // Reset during ACCUM, with a nonzero previous beat still sitting on the outputs.
      make_tex(5);
      launch(32, 32);
      wait_valid(lat);
      chk("pre_rst_disp", out_disp, 5);
      launch(40, 40);
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", {out_valid, out_disp, out_col, out_invalid, out_last}, 0);
      chk("midrst_ready", band_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      make_tex(5);
      launch(33, 33);
      wait_valid(lat);
      chk("postrst_latency", lat, 65);
      chk("postrst_disp", out_disp, 5);
      chk("postrst_col", out_col, 33);
      chk("postrst_last", out_last, 1);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
